tdm_demux_1x8: RTL and testbench
================================

TDM_DEMUX_1X8 -- requirements
Module: tdm_demux_1x8

Interface
REQ-001 Parameter SYNC_CHECK, default 1, meaning: 1 = a slot-0 bit without sync is a framing error; 0 = sync is required only to acquire lock.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 din  input  1  serial TDM data bit, sampled when en=1.
REQ-005 en  input  1  bit strobe; one TDM slot is consumed per clock with en=1.
REQ-006 sync  input  1  frame marker; high together with en on the slot-0 bit.
REQ-007 y0..y7  output  1 each  registered parallel frame; y<k> = bit received in slot k.
REQ-008 valid  output  1  one-cycle pulse; y0..y7 hold a newly completed frame.
REQ-009 s0,s1,s2  output  1 each  current slot index {s2,s1,s0} of the next expected bit.
REQ-010 lock  output  1  high while the state is LOCK.
REQ-011 err  output  1  one-cycle pulse on a framing error.
REQ-012 err_cnt  output  4  count of framing errors; saturates at 15.

Function
REQ-013 The FSM SHALL have two states, HUNT and LOCK; a 3-bit slot counter and an 8-bit shadow register.
REQ-014 With en=0, the FSM SHALL hold its state, the slot counter, the shadow register and y0..y7; valid and err SHALL be 0.
REQ-015 HUNT, en=1, sync=0: the bit SHALL be discarded, the state SHALL stay HUNT, and the slot SHALL stay 0.
REQ-016 HUNT, en=1, sync=1: din SHALL be written to shadow[0], the slot SHALL become 1, and the state SHALL become LOCK.
REQ-017 LOCK, en=1, sync=0, slot 1..6: din SHALL be written to shadow[slot] and the slot SHALL increment.
REQ-018 LOCK, en=1, sync=0, slot 7: on the same edge, y<k> SHALL load shadow[k] for k=0..6, y7 SHALL load din, valid SHALL be high for the following cycle, and the slot SHALL wrap to 0.
REQ-019 LOCK, en=1, slot 0, sync=1: this is a normal frame start; din SHALL go to shadow[0] and the slot SHALL become 1.
REQ-020 LOCK, en=1, slot 0, sync=0, SYNC_CHECK=1: err SHALL pulse, err_cnt SHALL increment, the bit SHALL be discarded, the slot SHALL stay 0, and the state SHALL become HUNT.
REQ-021 LOCK, en=1, slot 0, sync=0, SYNC_CHECK=0: the bit SHALL be treated as a slot-0 bit as in REQ-019, with no error.
REQ-022 LOCK, en=1, sync=1, slot 1..7 (early sync): err SHALL pulse and err_cnt SHALL increment; the partial frame SHALL be discarded with no valid and no y update; din SHALL go to shadow[0], the slot SHALL become 1, and the state SHALL stay LOCK.
REQ-023 Early sync at slot 7 SHALL follow REQ-022, not REQ-018; the frame SHALL NOT be published.
REQ-024 The latency from the slot-7 bit edge to valid=1 and y updated SHALL be 1 clock (outputs registered); y0..y7 SHALL hold until the next publish or reset.
REQ-025 valid and err SHALL never be high in the same cycle.
REQ-026 err_cnt at 15 SHALL stay 15 on further errors; err SHALL still pulse.
REQ-027 s2..s0 and lock SHALL reflect the registered slot counter and state directly.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force the state to HUNT, the slot to 0 and the shadow register to 0.
REQ-029 rst=1 SHALL likewise force y0..y7=0, valid=0, err=0, err_cnt=0, lock=0 and s2..s0=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, no valid SHALL occur before a new sync.
REQ-031 The first active edge after rst deasserts SHALL be processed normally.

Verification
REQ-032 Reset, then 8 consecutive en=1 bits 1,0,1,1,0,0,1,0 with sync on the first -> one clock after bit 8, valid=1 and y0..y7=1,0,1,1,0,0,1,0; lock=1; slot=0.
REQ-033 Sync first at bit 3 after reset, with bits before it -> those bits are ignored, lock rises on the sync bit, and the frame publishes 7 en-cycles later.
REQ-034 Locked; sync at slot 5 -> err pulse, err_cnt=1, no valid, and the next valid occurs 8 bits after the early sync.
REQ-035 Locked, SYNC_CHECK=1; slot-0 bit without sync -> err pulse, lock=0, HUNT; with SYNC_CHECK=0 the same stimulus -> no err and the frame publishes normally.
REQ-036 en toggling 1/0 every cycle across a frame -> same y values as the contiguous case; valid arrives 1 clock after the 8th strobed bit.
REQ-037 Sixteen early-sync errors -> err_cnt=15; rst pulsed mid-frame asynchronously -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/tdm_demux_1x8.sv
// Serial TDM demultiplexer: collects eight bits per frame, aligned to a slot-0
// sync marker, and publishes them as a registered parallel word.
module tdm_demux_1x8 #(
   parameter int SYNC_CHECK = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       en,
   input  logic       sync,
   output logic       y0,
   output logic       y1,
   output logic       y2,
   output logic       y3,
   output logic       y4,
   output logic       y5,
   output logic       y6,
   output logic       y7,
   output logic       valid,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       lock,
   output logic       err,
   output logic [3:0] err_cnt
);

   localparam logic [0:0] HUNT = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   localparam logic CHECK_EN = (SYNC_CHECK != 32'sd0);

   logic [0:0] state_r;
   logic [0:0] state_s;
   logic [2:0] slot_r;
   logic [2:0] slot_s;
   logic [7:0] shadow_r;
   logic [7:0] shadow_s;
   logic [7:0] y_r;
   logic [7:0] y_s;
   logic       valid_r;
   logic       valid_s;
   logic       err_r;
   logic       err_s;
   logic [3:0] err_cnt_r;
   logic [3:0] err_cnt_s;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? v : v + 4'd1;
   endfunction

   // Next-state decode for framing, shadow capture and publish
   always_comb begin
      state_s   = state_r;
      slot_s    = slot_r;
      shadow_s  = shadow_r;
      y_s       = y_r;
      valid_s   = 1'b0;
      err_s     = 1'b0;
      err_cnt_s = err_cnt_r;
      if (en) begin
         case (state_r)
            HUNT: begin
               if (sync) begin
                  shadow_s[0] = din;
                  slot_s      = 3'd1;
                  state_s     = LOCK;
               end else begin
                  slot_s = 3'd0;
               end
            end
            LOCK: begin
               // An early sync restarts the frame; it wins over a slot-7 publish
               if (sync && (slot_r != 3'd0)) begin
                  err_s       = 1'b1;
                  err_cnt_s   = sat_inc(err_cnt_r);
                  shadow_s[0] = din;
                  slot_s      = 3'd1;
               end else if (slot_r == 3'd0) begin
                  if (sync || !CHECK_EN) begin
                     shadow_s[0] = din;
                     slot_s      = 3'd1;
                  end else begin
                     err_s     = 1'b1;
                     err_cnt_s = sat_inc(err_cnt_r);
                     slot_s    = 3'd0;
                     state_s   = HUNT;
                  end
               end else if (slot_r == 3'd7) begin
                  shadow_s[7] = din;
                  y_s         = shadow_s;
                  valid_s     = 1'b1;
                  slot_s      = 3'd0;
               end else begin
                  shadow_s[slot_r] = din;
                  slot_s           = slot_r + 3'd1;
               end
            end
            default: begin
               state_s = HUNT;
               slot_s  = 3'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= HUNT;
         slot_r    <= 3'd0;
         shadow_r  <= 8'd0;
         y_r       <= 8'd0;
         valid_r   <= 1'b0;
         err_r     <= 1'b0;
         err_cnt_r <= 4'd0;
      end else begin
         state_r   <= state_s;
         slot_r    <= slot_s;
         shadow_r  <= shadow_s;
         y_r       <= y_s;
         valid_r   <= valid_s;
         err_r     <= err_s;
         err_cnt_r <= err_cnt_s;
      end
   end

   assign y0      = y_r[0];
   assign y1      = y_r[1];
   assign y2      = y_r[2];
   assign y3      = y_r[3];
   assign y4      = y_r[4];
   assign y5      = y_r[5];
   assign y6      = y_r[6];
   assign y7      = y_r[7];
   assign valid   = valid_r;
   assign err     = err_r;
   assign err_cnt = err_cnt_r;
   assign s0      = slot_r[0];
   assign s1      = slot_r[1];
   assign s2      = slot_r[2];
   assign lock    = (state_r == LOCK);

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Scoreboard bench: two instances (sync checking on and off) share one serial
// stream and are compared against a frame-level reference model.
module tb_tdm_demux_1x8;

   logic clk = 1'b0;
   logic rst;
   logic din;
   logic en;
   logic sync;

   wire [7:0] a_y;
   wire [7:0] b_y;
   wire       a_valid, b_valid, a_err, b_err, a_lock, b_lock;
   wire [2:0] a_s;
   wire [2:0] b_s;
   wire [3:0] a_ec;
   wire [3:0] b_ec;

   int total = 0;
   int passed = 0;

   // reference model state: index 0 = SYNC_CHECK 1, index 1 = SYNC_CHECK 0
   bit         m_locked [2];
   int         m_fill   [2];
   logic [7:0] m_acc    [2];
   int         m_errs   [2];
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];

   always #5 clk = ~clk;

   tdm_demux_1x8 #(.SYNC_CHECK(1)) dut_a (
      .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
      .y0(a_y[0]), .y1(a_y[1]), .y2(a_y[2]), .y3(a_y[3]),
      .y4(a_y[4]), .y5(a_y[5]), .y6(a_y[6]), .y7(a_y[7]),
      .valid(a_valid), .s0(a_s[0]), .s1(a_s[1]), .s2(a_s[2]),
      .lock(a_lock), .err(a_err), .err_cnt(a_ec));

   tdm_demux_1x8 #(.SYNC_CHECK(0)) dut_b (
      .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
      .y0(b_y[0]), .y1(b_y[1]), .y2(b_y[2]), .y3(b_y[3]),
      .y4(b_y[4]), .y5(b_y[5]), .y6(b_y[6]), .y7(b_y[7]),
      .valid(b_valid), .s0(b_s[0]), .s1(b_s[1]), .s2(b_s[2]),
      .lock(b_lock), .err(b_err), .err_cnt(b_ec));

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s dut%0d: got %0h want %0h", name, idx, act, exp);
   endtask

   task automatic push(input int idx, input logic [8:0] ev);
      if (idx == 0) q0.push_back(ev);
      else q1.push_back(ev);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_locked[i] = 1'b0;
         m_fill[i]   = 0;
         m_acc[i]    = 8'h00;
         m_errs[i]   = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   // one strobed bit at frame level: fill = bits collected in the current frame
   task automatic model_step(input int idx, input bit sc);
      if (!en) return;
      if (!m_locked[idx]) begin
         if (sync) begin
            m_locked[idx] = 1'b1;
            m_acc[idx] = {7'd0, din};
            m_fill[idx] = 1;
         end
      end else if (sync && m_fill[idx] != 0) begin
         m_errs[idx]++;
         push(idx, 9'h100);
         m_acc[idx] = {7'd0, din};
         m_fill[idx] = 1;
      end else if (m_fill[idx] == 0 && !sync && sc) begin
         m_errs[idx]++;
         push(idx, 9'h100);
         m_locked[idx] = 1'b0;
      end else begin
         m_acc[idx][m_fill[idx]] = din;
         m_fill[idx]++;
         if (m_fill[idx] == 8) begin
            push(idx, {1'b0, m_acc[idx]});
            m_fill[idx] = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
         end
      end
   end

   task automatic check_dut(input int idx, input logic [7:0] y, input logic v, input logic e,
                            input logic lk, input logic [2:0] s, input logic [3:0] ec);
      logic [8:0] ev;
      int sat;
      sat = (m_errs[idx] > 15) ? 15 : m_errs[idx];
      if (v && e) chk("valid_err_overlap", idx, 32'd1, 32'd0);
      if (v || e) begin
         if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            chk("unexpected_output", idx, {30'd0, v, e}, 32'd0);
         end else begin
            ev = (idx == 0) ? q0.pop_front() : q1.pop_front();
            chk("event_kind_err", idx, {31'd0, e}, {31'd0, ev[8]});
            if (v) chk("frame_data", idx, {24'd0, y}, {24'd0, ev[7:0]});
         end
      end
      chk("lock", idx, {31'd0, lk}, {31'd0, m_locked[idx]});
      chk("slot", idx, {29'd0, s}, m_fill[idx]);
      chk("err_cnt", idx, {28'd0, ec}, sat);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_dut(0, a_y, a_valid, a_err, a_lock, a_s, a_ec);
         check_dut(1, b_y, b_valid, b_err, b_lock, b_s, b_ec);
      end
   end

   task automatic strobe(input logic d, input logic s);
      @(negedge clk);
      en = 1'b1; din = d; sync = s;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         en = 1'b0; din = 1'($urandom); sync = 1'($urandom);
      end
   endtask

   task automatic check_all_zero(input string name);
      chk(name, 0, {a_y, 4'd0, a_ec, 1'b0, a_s, a_valid, a_err, a_lock}, 32'd0);
      chk(name, 1, {b_y, 4'd0, b_ec, 1'b0, b_s, b_valid, b_err, b_lock}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] bits, input int spacing);
      for (int i = 0; i < 8; i++) begin
         strobe(bits[i], i == 0);
         if (spacing > 0) gap(spacing);
      end
   endtask

   initial begin
      logic [7:0] pat;
      int r;
      rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      rst = 1'b0;

      // contiguous frame 1,0,1,1,0,0,1,0
      pat = 8'h4D;
      send_frame(pat, 0);
      gap(1);
      chk("frame_valid", 0, {31'd0, a_valid}, 32'd1);
      chk("frame_y", 0, {24'd0, a_y}, 32'h4D);
      chk("frame_lock", 0, {31'd0, a_lock}, 32'd1);
      chk("frame_slot", 0, {29'd0, a_s}, 32'd0);

      // junk bits before first sync
      do_reset();
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      send_frame(8'hA6, 0);
      gap(2);

      // early sync at slot 5, then full frame from that sync
      send_frame(8'h00, 0);
      for (int i = 0; i < 5; i++) strobe(1'b1, i == 0);
      strobe(1'b0, 1'b1);
      gap(1);
      chk("early_err", 0, {31'd0, a_err}, 32'd1);
      chk("early_novalid", 0, {31'd0, a_valid}, 32'd0);
      for (int i = 0; i < 7; i++) strobe(i[0], 1'b0);
      gap(2);

      // slot-0 bit without sync
      strobe(1'b1, 1'b0);
      gap(1);
      chk("nosync_err", 0, {31'd0, a_err}, 32'd1);
      chk("nosync_lock", 0, {31'd0, a_lock}, 32'd0);
      chk("nosync_err", 1, {31'd0, b_err}, 32'd0);
      for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0);
      gap(1);
      chk("nosync_publish", 1, {31'd0, b_valid}, 32'd1);

      // strobe toggling every cycle
      send_frame(8'h4D, 1);
      chk("toggle_valid", 0, {31'd0, a_valid}, 32'd1);
      chk("toggle_y", 0, {24'd0, a_y}, 32'h4D);
      gap(1);

      // err_cnt saturation, then asynchronous reset mid-frame
      do_reset();
      strobe(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         strobe(1'b1, 1'b0);
         strobe(1'b0, 1'b1);
      end
      gap(1);
      chk("err_sat", 0, {28'd0, a_ec}, 32'd15);
      chk("err_sat_pulse", 0, {31'd0, a_err}, 32'd1);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      @(negedge clk);
      en = 1'b0;
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) strobe(1'b1, 1'b0);
      gap(1);

      // randomized traffic, biased to keep frames aligned most of the time
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         en = ($urandom_range(0, 3) != 0);
         din = 1'($urandom);
         if (!m_locked[0] || m_fill[0] == 0) sync = (r < 85);
         else sync = (r < 3);
         if (r == 50 && $urandom_range(0, 9) == 0) begin
            en = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      gap(3);
      chk("queue_drained", 0, q0.size(), 32'd0);
      chk("queue_drained", 1, q1.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
